// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pipe
//  Description : Registered bitwise logic unit. Computes one of eight bitwise
//                operations on two WIDTH-bit operands, derives zero / parity /
//                all-ones flags, and queues {result, flags} in a DEPTH-entry
//                output FIFO with valid/ready handshakes on both sides.
//                Optional macro LOGIC_UNIT_POPCOUNT_EN adds a per-entry
//                population count output (out_popcount).
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [2:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_zero,
    output logic                     out_parity,
    output logic                     out_all_ones,
`ifdef LOGIC_UNIT_POPCOUNT_EN
    output logic [$clog2(WIDTH+1)-1:0] out_popcount,
`endif
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    localparam int PC_W       = $clog2(WIDTH + 1);
    localparam int PC_FIELD_W = PC_W;
`else
    localparam int PC_FIELD_W = 0;
`endif
    // Entry layout (MSB..LSB): result, zero, parity, all_ones [, popcount]
    localparam int ENTRY_W = WIDTH + 3 + PC_FIELD_W;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;
    localparam logic [2:0] OP_NOTA = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q,  count_d;
    logic [ENTRY_W-1:0]   mem_q [DEPTH];

    logic [WIDTH-1:0]     op_result;
    logic [ENTRY_W-1:0]   new_entry;
    logic [ENTRY_W-1:0]   head_entry;
    logic                 push;
    logic                 pop;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    logic [PC_W-1:0]      op_popcnt;
`endif

    // Handshake status comes from the registered FSM state only
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Bitwise operation selected by in_op
    always_comb begin
        op_result = '0;
        case (in_op)
            OP_AND:  op_result = in_a & in_b;
            OP_OR:   op_result = in_a | in_b;
            OP_XOR:  op_result = in_a ^ in_b;
            OP_NAND: op_result = ~(in_a & in_b);
            OP_NOR:  op_result = ~(in_a | in_b);
            OP_XNOR: op_result = ~(in_a ^ in_b);
            OP_ANDN: op_result = in_a & ~in_b;
            OP_NOTA: op_result = ~in_a;
            default: op_result = '0;
        endcase
    end

`ifdef LOGIC_UNIT_POPCOUNT_EN
    // Population count of the freshly computed result
    always_comb begin
        op_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            op_popcnt = op_popcnt + PC_W'(op_result[i]);
        end
    end

    assign new_entry = {op_result, ~|op_result, ^op_result, &op_result, op_popcnt};
`else
    assign new_entry = {op_result, ~|op_result, ^op_result, &op_result};
`endif

    // Pointer and occupancy next-state; full-cycle pushes are already
    // blocked by in_ready, so a pop at full never admits a new entry
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control FSM next-state, tracking occupancy class
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (count_d == CNT_W'(DEPTH)) begin
                    state_d = ST_FULL;
                end else if (count_d == '0) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_PARTIAL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State, pointer and count registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; only accepted transactions are written, so idle-cycle
    // operand values never reach state
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // Head fields are forced to zero whenever the FIFO is empty
    assign head_entry   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_result   = head_entry[ENTRY_W-1 -: WIDTH];
    assign out_zero     = head_entry[PC_FIELD_W + 2];
    assign out_parity   = head_entry[PC_FIELD_W + 1];
    assign out_all_ones = head_entry[PC_FIELD_W];
    assign out_count    = count_q;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    assign out_popcount = head_entry[PC_W-1:0];
`endif

endmodule
`default_nettype wire
